// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Definitions shared by the SRAM wrapper and its feeders.
//   DEFAULT_X_RES / DEFAULT_Y_RES / DEFAULT_PRECISION : image geometry defaults
//   pixel_entry_t : one buffered SPI pixel {x, y, rgb}; also the FIFO word
//   phase_t       : byte-pair assembly phase of the SPI image loader
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int DEFAULT_X_RES     = 800;
    localparam int DEFAULT_Y_RES     = 600;
    localparam int DEFAULT_PRECISION = 11;

    typedef struct packed {
        logic [DEFAULT_PRECISION-1:0] x;
        logic [DEFAULT_PRECISION-1:0] y;
        logic [15:0]                  rgb;
    } pixel_entry_t;

    // LOW_PENDING: next byte is the high byte of a new pixel.
    // HIGH_HELD:   high byte latched, next byte completes the pixel.
    typedef enum logic {
        LOW_PENDING = 1'b0,
        HIGH_HELD   = 1'b1
    } phase_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO: the head word is always present on rdata
// while not empty, and pop consumes it on the same clock edge.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (pointers only)
//   push, wdata  : write request and word; ignored when full unless popping
//   pop          : consume head word; ignored when empty
//   rdata        : head word (undefined while empty)
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves on the same edge:
    // the write lands in the slot being vacated.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    assign rdata = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_image_loader.sv
// -----------------------------------------------------------------------------
// spi_image_loader
// Assembles SPI bytes into RGB565 pixels, tags each with a raster coordinate,
// buffers them and drains one pixel per free SRAM slot.
// Optional build macro: SPI_LOADER_DROP_COUNT_EN enables the saturating
// dropped-pixel counter; otherwise drop_count is tied to zero.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   byte_valid     : byte_data carries an SPI byte this cycle
//   byte_data      : SPI byte (high byte first)
//   frame_start    : restart the image at (0,0); buffered pixels still drain
//   slot_free      : SRAM accepts an SPI write this cycle
//   spi_active     : head pixel presented and consumed this cycle
//   spi_pixel_in   : RGB565 head pixel
//   spi_pixel_x/y  : head pixel coordinate, signed, zero-extended
//   fifo_full      : buffer holds FIFO_DEPTH entries
//   overflow       : sticky, a pixel was dropped since rst/frame_start
//   image_done     : one-cycle pulse after the last pixel of the image
//   drop_count     : number of dropped pixels (saturating)
// -----------------------------------------------------------------------------
module spi_image_loader
    import sram_pkg::*;
#(
    parameter int X_RES      = DEFAULT_X_RES,
    parameter int Y_RES      = DEFAULT_Y_RES,
    parameter int PRECISION  = DEFAULT_PRECISION,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  frame_start,
    input  logic                  slot_free,
    output logic                  spi_active,
    output logic [15:0]           spi_pixel_in,
    output logic signed [PRECISION:0] spi_pixel_x,
    output logic signed [PRECISION:0] spi_pixel_y,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  image_done,
    output logic [15:0]           drop_count
);

    localparam logic [PRECISION-1:0] X_LAST = PRECISION'(X_RES - 1);
    localparam logic [PRECISION-1:0] Y_LAST = PRECISION'(Y_RES - 1);

    phase_t               phase_q, phase_d;
    logic [7:0]           hi_q, hi_d;
    logic [PRECISION-1:0] cur_x_q, cur_x_d;
    logic [PRECISION-1:0] cur_y_q, cur_y_d;
    logic                 overflow_q, overflow_d;
    logic                 image_done_q, image_done_d;

    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;
    pixel_entry_t         wr_entry;
    pixel_entry_t         head;

    sync_fifo #(
        .WIDTH ($bits(pixel_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Drain side is independent of the byte stream.
    assign pop        = ~empty & slot_free;
    assign spi_active = pop;
    assign fifo_full  = full;
    assign overflow   = overflow_q;
    assign image_done = image_done_q;

    // Head fields are forced to zero while empty so idle outputs are defined.
    assign spi_pixel_in = empty ? 16'h0000 : head.rgb;
    assign spi_pixel_x  = empty ? '0 : $signed({1'b0, PRECISION'(head.x)});
    assign spi_pixel_y  = empty ? '0 : $signed({1'b0, PRECISION'(head.y)});

    always_comb begin
        phase_d      = phase_q;
        hi_d         = hi_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        overflow_d   = overflow_q;
        image_done_d = 1'b0;
        push         = 1'b0;
        drop         = 1'b0;

        wr_entry.x   = DEFAULT_PRECISION'(cur_x_q);
        wr_entry.y   = DEFAULT_PRECISION'(cur_y_q);
        wr_entry.rgb = {hi_q, byte_data};

        if (frame_start) begin
            // A byte arriving with frame_start opens pixel (0,0).
            cur_x_d    = '0;
            cur_y_d    = '0;
            overflow_d = 1'b0;
            phase_d    = byte_valid ? HIGH_HELD : LOW_PENDING;
            if (byte_valid) hi_d = byte_data;
        end else if (byte_valid) begin
            if (phase_q == LOW_PENDING) begin
                hi_d    = byte_data;
                phase_d = HIGH_HELD;
            end else begin
                phase_d = LOW_PENDING;
                push    = ~full | pop;
                drop    = ~push;
                if (drop) overflow_d = 1'b1;
                // Cursor advances whether the pixel was kept or dropped.
                if (cur_x_q == X_LAST) begin
                    cur_x_d = '0;
                    if (cur_y_q == Y_LAST) begin
                        cur_y_d      = '0;
                        image_done_d = 1'b1;
                    end else begin
                        cur_y_d = cur_y_q + 1'b1;
                    end
                end else begin
                    cur_x_d = cur_x_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= LOW_PENDING;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            overflow_q   <= 1'b0;
            image_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            overflow_q   <= overflow_d;
            image_done_q <= image_done_d;
        end
    end

    // High byte is data only; the phase reset discards it.
    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

`ifdef SPI_LOADER_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (frame_start) begin
            drop_count_d = '0;
        end else if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drop_count_q <= '0;
        else     drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_image_loader.sv
module tb_spi_image_loader;

    localparam int X   = 20;
    localparam int Y   = 6;
    localparam int P   = 11;
    localparam int DEP = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                frame_start;
    logic                slot_free;
    logic                spi_active;
    logic [15:0]         spi_pixel_in;
    logic signed [P:0]   spi_pixel_x;
    logic signed [P:0]   spi_pixel_y;
    logic                fifo_full;
    logic                overflow;
    logic                image_done;
    logic [15:0]         drop_count;

    spi_image_loader #(
        .X_RES(X), .Y_RES(Y), .PRECISION(P), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .frame_start(frame_start), .slot_free(slot_free),
        .spi_active(spi_active), .spi_pixel_in(spi_pixel_in),
        .spi_pixel_x(spi_pixel_x), .spi_pixel_y(spi_pixel_y),
        .fifo_full(fifo_full), .overflow(overflow), .image_done(image_done),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rgb;
        int          x;
        int          y;
    } ent_t;

    // Reference model: a pixel index within the frame, a list of buffered
    // pixels, and the pixels expected to leave the loader in order.
    ent_t mq[$];
    ent_t exp_q[$];
    ent_t obs_q[$];
    int   exp_done[$];
    int   obs_done[$];
    bit   m_pend;
    logic [7:0] m_hi;
    int   m_idx;
    bit   m_ovf;
    int   m_drop;
    int   cyc;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int exp_drop();
`ifdef SPI_LOADER_DROP_COUNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    // Index of first differing consumed pixel, or -1 if streams match.
    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (obs_q[i].rgb !== exp_q[i].rgb || obs_q[i].x != exp_q[i].x ||
                obs_q[i].y != exp_q[i].y) return i;
        end
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic step(input bit bv, input logic [7:0] bd, input bit fs, input bit sf);
        ent_t e;
        byte_valid  = bv;
        byte_data   = bd;
        frame_start = fs;
        slot_free   = sf;
        @(negedge clk);
        if (spi_active === 1'b1) begin
            e.rgb = spi_pixel_in;
            e.x   = int'(spi_pixel_x);
            e.y   = int'(spi_pixel_y);
            obs_q.push_back(e);
        end
        if (image_done === 1'b1) obs_done.push_back(cyc);
        if (mq.size() > 0 && sf) exp_q.push_back(mq.pop_front());
        if (fs) begin
            m_idx  = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
            m_pend = bv;
            m_hi   = bd;
        end else if (bv) begin
            if (!m_pend) begin
                m_hi   = bd;
                m_pend = 1'b1;
            end else begin
                m_pend = 1'b0;
                e.rgb  = {m_hi, bd};
                e.x    = m_idx % X;
                e.y    = m_idx / X;
                if (m_idx == X * Y - 1) exp_done.push_back(cyc + 1);
                m_idx = (m_idx + 1) % (X * Y);
                if (mq.size() < DEP) mq.push_back(e);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: slot_free low, 1: slot_free high, 2: mostly free with random gaps
    task automatic send_pixel(input logic [15:0] p, input int mode);
        bit sf;
        for (int b = 0; b < 2; b++) begin
            if (mode == 2) begin
                while ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, 1'b0, $urandom_range(0, 7) != 0);
                sf = ($urandom_range(0, 7) != 0);
            end else begin
                sf = (mode == 1);
            end
            step(1'b1, (b == 0) ? p[15:8] : p[7:0], 1'b0, sf);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0; byte_data = 8'h5A; frame_start = 1'b0; slot_free = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); exp_q.delete(); obs_q.delete();
        exp_done.delete(); obs_done.delete();
        m_pend = 1'b0; m_hi = 8'h00; m_idx = 0; m_ovf = 1'b0; m_drop = 0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        byte_valid = 1'b1; byte_data = 8'hC3; frame_start = 1'b0; slot_free = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        slot_free = 1'b1;
        #1;
        n_checks++; if (spi_active !== 1'b0) $display("FAIL reset_active got %b want 0", spi_active); else n_pass++;
        n_checks++; if (spi_pixel_in !== 16'h0) $display("FAIL reset_pixel got %h want 0000", spi_pixel_in); else n_pass++;
        n_checks++; if (spi_pixel_x !== '0) $display("FAIL reset_x got %0d want 0", spi_pixel_x); else n_pass++;
        n_checks++; if (spi_pixel_y !== '0) $display("FAIL reset_y got %0d want 0", spi_pixel_y); else n_pass++;
        n_checks++; if (fifo_full !== 1'b0) $display("FAIL reset_full got %b want 0", fifo_full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
        n_checks++; if (image_done !== 1'b0) $display("FAIL reset_done got %b want 0", image_done); else n_pass++;
        n_checks++; if (drop_count !== 16'h0) $display("FAIL reset_drop got %0d want 0", drop_count); else n_pass++;
        // A half pixel before reset must be discarded.
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        do_reset();
        send_pixel(16'h1357, 1);
        drain(2);
        n_checks++; if (obs_q.size() != 1 || obs_q[0].rgb !== 16'h1357)
            $display("FAIL reset_mid_pixel got n=%0d rgb=%h want n=1 rgb=1357", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].rgb : 16'hxxxx);
        else n_pass++;
    endtask

    task automatic test_first_pixel();
        do_reset();
        step(1'b1, 8'hF8, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b1);
        n_checks++; if (obs_q.size() != 0) $display("FAIL first_early got %0d pops want 0", obs_q.size()); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (obs_q.size() != 1) $display("FAIL first_latency got %0d pops want 1", obs_q.size());
        else begin
            n_pass++;
            n_checks++;
            if (obs_q[0].rgb !== 16'hF800 || obs_q[0].x != 0 || obs_q[0].y != 0)
                $display("FAIL first_value got %h@(%0d,%0d) want F800@(0,0)", obs_q[0].rgb, obs_q[0].x, obs_q[0].y);
            else n_pass++;
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (obs_q.size() != 1) $display("FAIL first_once got %0d pops want 1", obs_q.size()); else n_pass++;
    endtask

    task automatic test_overflow();
        int bad;
        do_reset();
        for (int i = 0; i < DEP; i++) send_pixel(16'($urandom), 0);
        n_checks++; if (fifo_full !== 1'b1) $display("FAIL ovf_full got %b want 1", fifo_full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow); else n_pass++;
        send_pixel(16'($urandom), 0);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
        n_checks++; if (drop_count !== 16'(exp_drop())) $display("FAIL ovf_drop got %0d want %0d", drop_count, exp_drop()); else n_pass++;
        drain(DEP + 4);
        n_checks++; if (first_diff() != -1) $display("FAIL ovf_stream diff at %0d got n=%0d want n=%0d", first_diff(), obs_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (obs_q.size() != DEP) $display("FAIL ovf_count got %0d want %0d", obs_q.size(), DEP); else n_pass++;
        bad = 0;
        foreach (obs_q[i]) if (obs_q[i].x != i || obs_q[i].y != 0) bad++;
        n_checks++; if (bad != 0) $display("FAIL ovf_coords got %0d misplaced want 0", bad); else n_pass++;
        n_checks++; if (fifo_full !== 1'b0) $display("FAIL ovf_drained_full got %b want 0", fifo_full); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] p;
        do_reset();
        for (int i = 0; i < DEP; i++) send_pixel(16'($urandom), 0);
        p = 16'($urandom);
        step(1'b1, p[15:8], 1'b0, 1'b0);
        step(1'b1, p[7:0], 1'b0, 1'b1);
        n_checks++; if (fifo_full !== 1'b1) $display("FAIL pushpop_full got %b want 1", fifo_full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL pushpop_overflow got %b want 0", overflow); else n_pass++;
        drain(DEP + 4);
        n_checks++; if (obs_q.size() != DEP + 1) $display("FAIL pushpop_count got %0d want %0d", obs_q.size(), DEP + 1); else n_pass++;
        n_checks++; if (first_diff() != -1) $display("FAIL pushpop_stream diff at %0d", first_diff()); else n_pass++;
    endtask

    task automatic test_row_wrap();
        do_reset();
        for (int i = 0; i < X + 1; i++) send_pixel(16'($urandom), 1);
        drain(4);
        n_checks++; if (obs_q.size() != X + 1) $display("FAIL wrap_count got %0d want %0d", obs_q.size(), X + 1);
        else begin
            n_pass++;
            n_checks++;
            if (obs_q[X-1].x != X - 1 || obs_q[X-1].y != 0)
                $display("FAIL wrap_last got (%0d,%0d) want (%0d,0)", obs_q[X-1].x, obs_q[X-1].y, X - 1);
            else n_pass++;
            n_checks++;
            if (obs_q[X].x != 0 || obs_q[X].y != 1)
                $display("FAIL wrap_next got (%0d,%0d) want (0,1)", obs_q[X].x, obs_q[X].y);
            else n_pass++;
        end
        n_checks++; if (first_diff() != -1) $display("FAIL wrap_stream diff at %0d", first_diff()); else n_pass++;
    endtask

    task automatic test_image_done();
        do_reset();
        for (int i = 0; i < X * Y + 1; i++) send_pixel(16'($urandom), 2);
        drain(DEP + 4);
        n_checks++; if (obs_done.size() != 1) $display("FAIL done_pulses got %0d want 1", obs_done.size());
        else begin
            n_pass++;
            n_checks++;
            if (exp_done.size() != 1 || obs_done[0] != exp_done[0])
                $display("FAIL done_timing got cycle %0d want %0d", obs_done[0], (exp_done.size() > 0) ? exp_done[0] : -1);
            else n_pass++;
        end
        n_checks++; if (first_diff() != -1) $display("FAIL done_stream diff at %0d got n=%0d want n=%0d", first_diff(), obs_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1].x != 0 || obs_q[obs_q.size()-1].y != 0)
            $display("FAIL done_restart last pixel not at (0,0), n=%0d", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_frame_start();
        do_reset();
        step(1'b1, 8'hAB, 1'b0, 1'b1);
        step(1'b1, 8'h12, 1'b1, 1'b1);
        step(1'b1, 8'h34, 1'b0, 1'b1);
        drain(3);
        n_checks++; if (obs_q.size() != 1 || obs_q[0].rgb !== 16'h1234 || obs_q[0].x != 0 || obs_q[0].y != 0)
            $display("FAIL fs_pixel got n=%0d rgb=%h want n=1 rgb=1234@(0,0)", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].rgb : 16'hxxxx);
        else n_pass++;
        for (int i = 0; i < DEP + 2; i++) send_pixel(16'($urandom), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL fs_overflow got %b want 0", overflow); else n_pass++;
        n_checks++; if (drop_count !== 16'h0) $display("FAIL fs_drop got %0d want 0", drop_count); else n_pass++;
        n_checks++; if (fifo_full !== 1'b1) $display("FAIL fs_keep got full=%b want 1", fifo_full); else n_pass++;
        send_pixel(16'hBEEF, 1);
        drain(DEP + 4);
        n_checks++; if (first_diff() != -1) $display("FAIL fs_stream diff at %0d got n=%0d want n=%0d", first_diff(), obs_q.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);
        n_checks++; if (overflow !== m_ovf) $display("FAIL rand_overflow got %b want %b", overflow, m_ovf); else n_pass++;
        n_checks++; if (drop_count !== 16'(exp_drop())) $display("FAIL rand_drop got %0d want %0d", drop_count, exp_drop()); else n_pass++;
        drain(DEP + 4);
        n_checks++; if (first_diff() != -1) $display("FAIL rand_stream diff at %0d got n=%0d want n=%0d", first_diff(), obs_q.size(), exp_q.size()); else n_pass++;
        bad = (obs_done.size() != exp_done.size()) ? 1 : 0;
        if (bad == 0) foreach (obs_done[i]) if (obs_done[i] != exp_done[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL rand_done got %0d pulses want %0d", obs_done.size(), exp_done.size()); else n_pass++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pixel();
        test_overflow();
        test_full_push_pop();
        test_row_wrap();
        test_image_done();
        test_frame_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
